// File: rtl/delay_sweep_sched.sv
// Delay-sweep scheduler: steps a pulse-generator delay word through n_points values,
// waiting one settling sync period and then gating n_avg recorded sync periods per point.
module delay_sweep_sched #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk_pll,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] del_start,
    input  logic [DW-1:0] del_step,
    input  logic [CW-1:0] n_points,
    input  logic [CW-1:0] n_avg,
    input  logic          sync_in,
    output logic [DW-1:0] delay_out,
    output logic          delay_load,
    output logic [CW-1:0] point_idx,
    output logic          record_gate,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_AVG    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [CW-1:0] CW_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r, state_next_s;
    logic          sync_d_r;
    logic          sync_edge_s;
    logic [DW-1:0] step_r, step_next_s;
    logic [CW-1:0] npts_r, npts_next_s;
    logic [CW-1:0] navg_r, navg_next_s;
    logic [CW-1:0] avg_cnt_r, avg_cnt_next_s;
    logic [DW-1:0] delay_out_r, delay_out_next_s;
    logic [CW-1:0] point_idx_r, point_idx_next_s;
    logic          delay_load_r, delay_load_next_s;
    logic          record_gate_r, record_gate_next_s;
    logic          busy_r, busy_next_s;
    logic          done_r, done_next_s;

    assign sync_edge_s = sync_in & ~sync_d_r;

    // Next-state and next-output decode; abort outranks every other event outside IDLE.
    always_comb begin
        state_next_s       = state_r;
        step_next_s        = step_r;
        npts_next_s        = npts_r;
        navg_next_s        = navg_r;
        avg_cnt_next_s     = avg_cnt_r;
        delay_out_next_s   = delay_out_r;
        point_idx_next_s   = point_idx_r;
        delay_load_next_s  = 1'b0;
        record_gate_next_s = 1'b0;
        done_next_s        = 1'b0;

        if (abort && (state_r != ST_IDLE)) begin
            state_next_s   = ST_IDLE;
            avg_cnt_next_s = CW_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        step_next_s = del_step;
                        npts_next_s = n_points;
                        navg_next_s = n_avg;
                        if ((n_points == CW_ZERO) || (n_avg == CW_ZERO)) begin
                            state_next_s = ST_DONE;
                            done_next_s  = 1'b1;
                        end else begin
                            state_next_s      = ST_LOAD;
                            delay_out_next_s  = del_start;
                            point_idx_next_s  = CW_ZERO;
                            delay_load_next_s = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // An edge coinciding with LOAD is ignored; SETTLE discards the next one.
                    state_next_s   = ST_SETTLE;
                    avg_cnt_next_s = CW_ZERO;
                end
                ST_SETTLE: begin
                    if (sync_edge_s) begin
                        state_next_s = ST_AVG;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end
                ST_AVG: begin
                    if (sync_edge_s && (avg_cnt_r == (navg_r - CW_ONE))) begin
                        avg_cnt_next_s = CW_ZERO;
                        if ((point_idx_r + CW_ONE) == npts_r) begin
                            state_next_s = ST_DONE;
                            done_next_s  = 1'b1;
                        end else begin
                            state_next_s      = ST_LOAD;
                            delay_out_next_s  = delay_out_r + step_r;
                            point_idx_next_s  = point_idx_r + CW_ONE;
                            delay_load_next_s = 1'b1;
                        end
                    end else if (sync_edge_s) begin
                        avg_cnt_next_s     = avg_cnt_r + CW_ONE;
                        record_gate_next_s = 1'b1;
                    end else begin
                        record_gate_next_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State, latched sweep parameters, sync delay line and registered outputs.
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            sync_d_r      <= 1'b0;
            step_r        <= {DW{1'b0}};
            npts_r        <= CW_ZERO;
            navg_r        <= CW_ZERO;
            avg_cnt_r     <= CW_ZERO;
            delay_out_r   <= {DW{1'b0}};
            point_idx_r   <= CW_ZERO;
            delay_load_r  <= 1'b0;
            record_gate_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            sync_d_r      <= sync_in;
            step_r        <= step_next_s;
            npts_r        <= npts_next_s;
            navg_r        <= navg_next_s;
            avg_cnt_r     <= avg_cnt_next_s;
            delay_out_r   <= delay_out_next_s;
            point_idx_r   <= point_idx_next_s;
            delay_load_r  <= delay_load_next_s;
            record_gate_r <= record_gate_next_s;
            busy_r        <= busy_next_s;
            done_r        <= done_next_s;
        end
    end

    assign delay_out   = delay_out_r;
    assign delay_load  = delay_load_r;
    assign point_idx   = point_idx_r;
    assign record_gate = record_gate_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_delay_sweep_sched.sv
// Bench for delay_sweep_sched: a table of sweeps with hand-computed results, plus
// hand-written abort, reset-during-settle and restart sequences. Sync period is 20 cycles.
module tb_delay_sweep_sched;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk_pll = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [DW-1:0] del_start;
    logic [DW-1:0] del_step;
    logic [CW-1:0] n_points;
    logic [CW-1:0] n_avg;
    logic          sync_in;
    logic [DW-1:0] delay_out;
    logic          delay_load;
    logic [CW-1:0] point_idx;
    logic          record_gate;
    logic          busy;
    logic          done;

    delay_sweep_sched #(.DW(DW), .CW(CW)) dut (
        .clk_pll     (clk_pll),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .del_start   (del_start),
        .del_step    (del_step),
        .n_points    (n_points),
        .n_avg       (n_avg),
        .sync_in     (sync_in),
        .delay_out   (delay_out),
        .delay_load  (delay_load),
        .point_idx   (point_idx),
        .record_gate (record_gate),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_pll = ~clk_pll;

    typedef struct {
        logic [31:0] ds;
        logic [31:0] dstep;
        logic [15:0] np;
        logic [15:0] navg;
        int          phase;
        int          perturb;
        int          abort_st;
        int          exp_loads;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
        int          exp_win;
        int          exp_edges;
        int          exp_done_cyc;
        logic [31:0] exp_final;
        logic [15:0] exp_idx;
    } vec_t;

    vec_t vecs[7];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          phase;
    int          cyc;
    int          edge_cnt;
    int          loads_seen;
    logic [31:0] load_vals[8];
    int          nwin;
    int          win_edges[8];
    int          cur_win;
    int          done_seen;
    int          edges_at_done;
    int          done_cyc;
    logic        gate_prev;
    logic        done_prev;
    logic        busy_after_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_mon();
        edge_cnt = 0; loads_seen = 0; nwin = 0; cur_win = 0;
        done_seen = 0; edges_at_done = 0; done_cyc = 0;
        gate_prev = 1'b0; done_prev = 1'b0; busy_after_done = 1'b1;
    endtask

    // One clock: sample outputs after the edge, then advance the sync waveform.
    task automatic tick();
        @(posedge clk_pll);
        #1;
        cyc++;
        if (delay_load) begin
            if (loads_seen < 8) load_vals[loads_seen] = delay_out;
            loads_seen++;
        end
        if (done) begin
            done_seen++;
            edges_at_done = edge_cnt;
            done_cyc = cyc;
        end
        if (done_prev) busy_after_done = busy;
        done_prev = done;
        if (gate_prev && !record_gate) begin
            if (nwin < 8) win_edges[nwin] = cur_win;
            nwin++;
            cur_win = 0;
        end
        gate_prev = record_gate;
        phase = (phase == 19) ? 0 : phase + 1;
        if (phase == 0) begin
            edge_cnt++;
            if (record_gate) cur_win++;
        end
        sync_in = (phase < 5);
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 25; k++) begin
            if (phase == ph) break;
            tick();
        end
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] ev[3];
        logic        timed_out;
        v = vecs[i];
        ev[0] = v.v0; ev[1] = v.v1; ev[2] = v.v2;
        wait_phase(v.phase);
        del_start = v.ds; del_step = v.dstep; n_points = v.np; n_avg = v.navg;
        start = 1'b1;
        abort = (v.abort_st != 0);
        clear_mon();
        cyc = 1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            start = (v.perturb != 0) && (k == 30);
            if (start) begin
                del_start = 32'd999; del_step = 32'd7; n_points = 16'd9; n_avg = 16'd9;
            end
            tick();
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_timeout", i), timed_out, 1'b0);
        chk($sformatf("v%0d_loads", i), loads_seen, v.exp_loads);
        for (int j = 0; j < v.exp_loads && j < 3; j++)
            chk($sformatf("v%0d_load_val%0d", i, j), load_vals[j], ev[j]);
        chk($sformatf("v%0d_windows", i), nwin, v.exp_loads);
        for (int j = 0; j < nwin && j < 8; j++)
            chk($sformatf("v%0d_win_edges%0d", i, j), win_edges[j], v.exp_win);
        chk($sformatf("v%0d_done_cnt", i), done_seen, 1);
        if (v.exp_edges != 0) chk($sformatf("v%0d_edges_at_done", i), edges_at_done, v.exp_edges);
        if (v.exp_done_cyc != 0) chk($sformatf("v%0d_done_cyc", i), done_cyc, v.exp_done_cyc);
        chk($sformatf("v%0d_busy_after_done", i), busy_after_done, 1'b0);
        chk($sformatf("v%0d_final_delay", i), delay_out, v.exp_final);
        chk($sformatf("v%0d_final_idx", i), point_idx, v.exp_idx);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_delay_out"}, delay_out, 32'd0);
        chk({pfx, "_point_idx"}, point_idx, 16'd0);
        chk({pfx, "_delay_load"}, delay_load, 1'b0);
        chk({pfx, "_record_gate"}, record_gate, 1'b0);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_done"}, done, 1'b0);
    endtask

    initial begin
        logic found;
        //            ds            step       np     navg  ph pt ab ld v0            v1           v2          win edg dc final        idx
        vecs[0] = '{32'd100,      32'd10,   16'd3, 16'd2, 10, 0, 0, 3, 32'd100,      32'd110,     32'd120,    2, 9, 0, 32'd120,      16'd2};
        vecs[1] = '{32'd777,      32'd1,    16'd0, 16'd5, 10, 0, 0, 0, 32'd0,        32'd0,       32'd0,      0, 0, 2, 32'd120,      16'd2};
        vecs[2] = '{32'hFFFFFFF0, 32'h20,   16'd2, 16'd1, 10, 0, 0, 2, 32'hFFFFFFF0, 32'h10,      32'd0,      1, 4, 0, 32'h10,       16'd1};
        vecs[3] = '{32'd55,       32'd5,    16'd4, 16'd0, 10, 0, 0, 0, 32'd0,        32'd0,       32'd0,      0, 0, 2, 32'h10,       16'd1};
        vecs[4] = '{32'd5,        32'd3,    16'd1, 16'd1, 19, 0, 0, 1, 32'd5,        32'd0,       32'd0,      1, 3, 0, 32'd5,        16'd0};
        vecs[5] = '{32'd100,      32'd10,   16'd3, 16'd2, 10, 1, 0, 3, 32'd100,      32'd110,     32'd120,    2, 9, 0, 32'd120,      16'd2};
        vecs[6] = '{32'd300,      32'd1,    16'd1, 16'd1, 10, 0, 1, 1, 32'd300,      32'd0,       32'd0,      1, 2, 0, 32'd300,      16'd0};

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        del_start = 32'd0; del_step = 32'd0; n_points = 16'd0; n_avg = 16'd0;
        phase = 0; sync_in = 1'b1; cyc = 0;
        clear_mon();
        #12;
        check_zero("reset");
        resetn = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Abort while recording the second point, then restart from del_start.
        wait_phase(10);
        del_start = 32'd100; del_step = 32'd10; n_points = 16'd3; n_avg = 16'd2;
        start = 1'b1;
        clear_mon();
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (point_idx == 16'd1 && record_gate) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach_point1", found, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_record_gate", record_gate, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_delay_load", delay_load, 1'b0);
        chk("abort_delay_out", delay_out, 32'd110);
        chk("abort_point_idx", point_idx, 16'd1);
        done_seen = 0;
        repeat (60) tick();
        chk("abort_no_done", done_seen, 0);
        chk("abort_delay_hold", delay_out, 32'd110);
        run_vec(0);

        // Reset asserted between clock edges while in SETTLE.
        wait_phase(10);
        start = 1'b1;
        clear_mon();
        tick();
        start = 1'b0;
        tick();
        chk("settle_busy", busy, 1'b1);
        chk("settle_delay_out", delay_out, 32'd100);
        #2 resetn = 1'b0;
        #1;
        check_zero("async_reset");
        #2 resetn = 1'b1;
        done_seen = 0;
        repeat (5) tick();
        chk("reset_no_done", done_seen, 0);
        run_vec(0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/delay_sweep_sched.md
DELAY_SWEEP_SCHED -- requirements
Module: delay_sweep_sched

Interface
REQ-001 SHALL have parameter DW, default 32, width of the delay, start and step words.
REQ-002 SHALL have parameter CW, default 16, width of the point and average counters.
REQ-003 SHALL have port clk_pll  input  1  the PLL clock, the only clock.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle sweep request.
REQ-006 SHALL have port abort  input  1  one-cycle sweep cancel.
REQ-007 SHALL have port del_start  input  DW  delay of the first point.
REQ-008 SHALL have port del_step  input  DW  delay increment per point.
REQ-009 SHALL have port n_points  input  CW  number of points in the sweep.
REQ-010 SHALL have port n_avg  input  CW  number of sync periods recorded per point.
REQ-011 SHALL have port sync_in  input  1  sync level from the pulse generator, synchronous to clk_pll.
REQ-012 SHALL have port delay_out  output  DW  delay word driven to the pulse generator.
REQ-013 SHALL have port delay_load  output  1  one-cycle strobe: delay_out just changed.
REQ-014 SHALL have port point_idx  output  CW  index of the current point, starting at 0.
REQ-015 SHALL have port record_gate  output  1  high while the current point's sync periods are recorded.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle strobe on normal sweep completion.

Function
REQ-018 SHALL implement the states IDLE, LOAD, SETTLE, AVG and DONE.
REQ-019 SHALL detect a sync edge as sync_in high while a one-cycle-delayed copy of sync_in is low (sync_in & ~sync_d).
REQ-020 IDLE: start high SHALL latch del_start, del_step, n_points and n_avg, and start is ignored in every other state.
REQ-021 IDLE: if the latched n_points or n_avg is 0, SHALL go to DONE, with no delay_load.
REQ-022 IDLE: otherwise, SHALL go to LOAD with point_idx=0 and delay_out=del_start, both registered in the cycle after start.
REQ-023 LOAD: delay_load SHALL be high for exactly this one cycle, and the next state SHALL be SETTLE.
REQ-024 SETTLE: the first sync edge SHALL be discarded (the new delay takes effect at the period boundary), and the next state SHALL be AVG.
REQ-025 AVG: record_gate SHALL be high from the cycle after entering AVG, and the internal counter SHALL count sync edges starting at 0.
REQ-026 AVG: on the n_avg-th edge, record_gate SHALL fall in the next cycle.
REQ-027 AVG end, if point_idx+1 == n_points: SHALL go to DONE.
REQ-028 AVG end, otherwise: SHALL set delay_out = delay_out + del_step (modulo 2^DW, overflow discarded), increment point_idx and go to LOAD.
REQ-029 DONE: done SHALL be high for exactly one cycle, then the state SHALL be IDLE.
REQ-030 DONE: delay_out and point_idx SHALL hold their last values.
REQ-031 abort in any non-IDLE state SHALL force IDLE on the next cycle, with record_gate, delay_load and done low, and no done strobe.
REQ-032 abort SHALL leave delay_out and point_idx unchanged.
REQ-033 abort SHALL take priority over a sync edge or state transition in the same cycle.
REQ-034 abort in IDLE SHALL have no effect, including when it is high in the same cycle as start.
REQ-035 A sync edge in the same cycle as the LOAD state SHALL NOT be counted (SETTLE waits for the next edge).
REQ-036 Changes on del_start, del_step, n_points or n_avg while busy SHALL NOT affect the running sweep.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 resetn low SHALL asynchronously force state=IDLE, delay_out=0, delay_load=0, point_idx=0, record_gate=0, busy=0, done=0, sync_d=0 and all counters to 0.
REQ-039 Reset asserted mid-sweep SHALL abandon the sweep with no done strobe.
REQ-040 After resetn rises, the first start SHALL be honoured.

Verification
REQ-041 SHALL cover: del_start=100, del_step=10, n_points=3, n_avg=2, sync_in period 20 cycles -> delay_load 3 times with delay_out 100, 110, 120; each record_gate window spans 2 sync edges; one done after the 9th counted/discarded edge; busy low the cycle after done.
REQ-042 SHALL cover: n_points=0, n_avg=5, start -> done high 2 cycles after start, no delay_load, no record_gate, delay_out unchanged.
REQ-043 SHALL cover: del_start=0xFFFFFFF0, del_step=0x20, n_points=2, n_avg=1 -> delay_out 0xFFFFFFF0 then 0x00000010, done once.
REQ-044 SHALL cover: abort in AVG at point_idx=1 -> record_gate low and busy low the next cycle, no done, delay_out holds the point-1 value; a subsequent start restarts at del_start.
REQ-045 SHALL cover: start pulsed again while busy, and inputs changed while busy -> sweep values and point count unchanged.
REQ-046 SHALL cover: resetn low during SETTLE -> all outputs 0 immediately, without a clock edge; after release, start runs a full sweep.
